// File: rtl/order_generator.sv
// order_generator
//   Turns a bid/ask quote pair into up to two limit orders (buy at bid, then
//   sell at ask) over a valid/ready handshake, then waits a fixed cooldown
//   before it accepts the next quote.
//
//   Ports
//     i_clk, i_reset          clock, asynchronous active-high reset
//     i_buy_price/i_ask_price quote pair, qualified by the i_data_valid pulse
//     i_order_ready           downstream sink can take an order
//     o_order_*               order payload, qualified by o_order_valid
//     o_busy                  FSM is not in IDLE
//     o_dropped               a quote was discarded without being evaluated
//     o_crossed               a quote was rejected because bid >= ask
module order_generator #(
    parameter int DATA_WIDTH     = 32,
    parameter int QTY_WIDTH      = 16,
    parameter int ID_WIDTH       = 16,
    parameter int DEFAULT_QTY    = 100,
    parameter int MIN_GAP_CYCLES = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_buy_price,
    input  logic [DATA_WIDTH-1:0] i_ask_price,
    input  logic                  i_data_valid,
    input  logic                  i_order_ready,
    output logic                  o_order_valid,
    output logic                  o_order_side,
    output logic [DATA_WIDTH-1:0] o_order_price,
    output logic [QTY_WIDTH-1:0]  o_order_qty,
    output logic [ID_WIDTH-1:0]   o_order_id,
    output logic                  o_busy,
    output logic                  o_dropped,
    output logic                  o_crossed
);

    // Counter holds MIN_GAP_CYCLES-1 down to 0.
    localparam int CW = (MIN_GAP_CYCLES > 1) ? $clog2(MIN_GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_BID = 2'd1,
        SEND_ASK = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_bid, r_ask;
    logic [DATA_WIDTH-1:0] r_last_bid, r_last_ask;
    logic                  r_pend_vld;
    logic [DATA_WIDTH-1:0] r_pend_bid, r_pend_ask;
    logic [CW-1:0]         r_cd_cnt;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_dropped, r_crossed;

    // Quote seen by the IDLE evaluator: a fresh quote wins over the pending one.
    logic                  w_have;
    logic [DATA_WIDTH-1:0] w_b, w_a;
    logic                  w_cross, w_dup;

    always_comb begin
        w_have  = i_data_valid | r_pend_vld;
        w_b     = i_data_valid ? i_buy_price : r_pend_bid;
        w_a     = i_data_valid ? i_ask_price : r_pend_ask;
        w_cross = (w_b != '0) && (w_a != '0) && (w_b >= w_a);
        w_dup   = (w_b == r_last_bid) && (w_a == r_last_ask);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_bid      <= '0;
            r_ask      <= '0;
            r_last_bid <= '0;
            r_last_ask <= '0;
            r_pend_vld <= 1'b0;
            r_pend_bid <= '0;
            r_pend_ask <= '0;
            r_cd_cnt   <= '0;
            r_id       <= '0;
            r_dropped  <= 1'b0;
            r_crossed  <= 1'b0;
        end else begin
            r_dropped <= 1'b0;
            r_crossed <= 1'b0;

            // Outside IDLE, quotes park in a one-deep slot; newest wins.
            if (r_state != IDLE && i_data_valid) begin
                r_pend_vld <= 1'b1;
                r_pend_bid <= i_buy_price;
                r_pend_ask <= i_ask_price;
                if (r_pend_vld) r_dropped <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_have) begin
                        r_pend_vld <= 1'b0;
                        if (i_data_valid && r_pend_vld) r_dropped <= 1'b1;
                        if (w_cross) begin
                            r_crossed <= 1'b1;
                        end else if (!w_dup) begin
                            r_bid      <= w_b;
                            r_ask      <= w_a;
                            r_last_bid <= w_b;
                            r_last_ask <= w_a;
                            if (w_b != '0)      r_state <= SEND_BID;
                            else if (w_a != '0) r_state <= SEND_ASK;
                        end
                    end
                end
                SEND_BID: begin
                    if (i_order_ready) begin
                        r_id <= r_id + ID_WIDTH'(1);
                        if (r_ask != '0) begin
                            r_state <= SEND_ASK;
                        end else begin
                            r_state  <= COOLDOWN;
                            r_cd_cnt <= CW'(MIN_GAP_CYCLES - 1);
                        end
                    end
                end
                SEND_ASK: begin
                    if (i_order_ready) begin
                        r_id     <= r_id + ID_WIDTH'(1);
                        r_state  <= COOLDOWN;
                        r_cd_cnt <= CW'(MIN_GAP_CYCLES - 1);
                    end
                end
                COOLDOWN: begin
                    if (r_cd_cnt == '0) r_state  <= IDLE;
                    else                r_cd_cnt <= r_cd_cnt - CW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Payload is a pure decode of registered state, so async reset clears
    // every output without waiting for an edge.
    logic w_valid;
    assign w_valid       = (r_state == SEND_BID) || (r_state == SEND_ASK);
    assign o_order_valid = w_valid;
    assign o_order_side  = (r_state == SEND_ASK);
    assign o_order_price = !w_valid ? '0 : ((r_state == SEND_ASK) ? r_ask : r_bid);
    assign o_order_qty   = w_valid ? QTY_WIDTH'(DEFAULT_QTY) : '0;
    assign o_order_id    = r_id;
    assign o_busy        = (r_state != IDLE);
    assign o_dropped     = r_dropped;
    assign o_crossed     = r_crossed;

endmodule

// File: tb/tb_order_generator.sv
// Directed bench for order_generator. ID width is reduced to 8 bits so the
// id wrap (all-ones followed by zero) is reachable in a short run.
module tb_order_generator;
    localparam int DW  = 32;
    localparam int QW  = 16;
    localparam int IDW = 8;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic [DW-1:0] i_buy_price = '0, i_ask_price = '0;
    logic          i_data_valid = 1'b0, i_order_ready = 1'b0;
    logic          o_order_valid, o_order_side, o_busy, o_dropped, o_crossed;
    logic [DW-1:0] o_order_price;
    logic [QW-1:0] o_order_qty;
    logic [IDW-1:0] o_order_id;

    int n_chk = 0, n_pass = 0;
    int exp_id = 0;

    order_generator #(.DATA_WIDTH(DW), .QTY_WIDTH(QW), .ID_WIDTH(IDW),
                      .DEFAULT_QTY(100), .MIN_GAP_CYCLES(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_buy_price(i_buy_price), .i_ask_price(i_ask_price),
        .i_data_valid(i_data_valid), .i_order_ready(i_order_ready),
        .o_order_valid(o_order_valid), .o_order_side(o_order_side),
        .o_order_price(o_order_price), .o_order_qty(o_order_qty),
        .o_order_id(o_order_id), .o_busy(o_busy),
        .o_dropped(o_dropped), .o_crossed(o_crossed)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge i_clk); #1;
    endtask

    task automatic quote(input logic [DW-1:0] b, input logic [DW-1:0] a);
        i_buy_price = b; i_ask_price = a; i_data_valid = 1'b1;
        step();
        i_data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && o_busy; i++) step();
        chk("idle_wait", o_busy, 0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 100 && !o_order_valid; i++) step();
        chk("valid_wait", o_order_valid, 1);
    endtask

    task automatic chk_order(input string tag, input logic side, input logic [DW-1:0] p, input int id);
        chk({tag, "_vld"},   o_order_valid, 1);
        chk({tag, "_side"},  o_order_side, side);
        chk({tag, "_price"}, o_order_price, p);
        chk({tag, "_qty"},   o_order_qty, 100);
        chk({tag, "_id"},    o_order_id, id[IDW-1:0]);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vld"},   o_order_valid, 0);
        chk({tag, "_side"},  o_order_side, 0);
        chk({tag, "_price"}, o_order_price, 0);
        chk({tag, "_qty"},   o_order_qty, 0);
        chk({tag, "_id"},    o_order_id, 0);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_drop"},  o_dropped, 0);
        chk({tag, "_cross"}, o_crossed, 0);
    endtask

    initial begin
        // Reset state
        #1 chk_zero("rst");
        step(); step();
        i_reset = 1'b0;
        step();

        // Basic two-sided quote, then exact 8-cycle cooldown
        i_order_ready = 1'b1;
        quote(100, 102);
        chk_order("bid0", 0, 100, 0);
        chk("bid0_busy", o_busy, 1);
        step();
        chk_order("ask0", 1, 102, 1);
        step();
        for (int i = 0; i < 8; i++) begin
            chk("cd_busy", o_busy, 1);
            chk("cd_vld", o_order_valid, 0);
            step();
        end
        chk("cd_done", o_busy, 0);
        exp_id = 2;

        // Crossed quote
        quote(105, 103);
        chk("cross_pulse", o_crossed, 1);
        chk("cross_vld", o_order_valid, 0);
        chk("cross_busy", o_busy, 0);
        step();
        chk("cross_end", o_crossed, 0);

        // Dedup, then ask-only
        quote(100, 102);
        chk("dup_vld", o_order_valid, 0);
        chk("dup_busy", o_busy, 0);
        quote(0, 101);
        chk_order("askonly", 1, 101, exp_id);
        exp_id++;
        step();
        chk("askonly_cd", o_order_valid, 0);
        wait_idle();

        // Backpressure with two queued quotes
        i_order_ready = 1'b0;
        quote(200, 210);
        chk_order("stall1", 0, 200, exp_id);
        quote(201, 211);
        chk_order("stall2", 0, 200, exp_id);
        chk("drop_none", o_dropped, 0);
        quote(202, 212);
        chk_order("stall3", 0, 200, exp_id);
        chk("drop_pulse", o_dropped, 1);
        step();
        chk_order("stall4", 0, 200, exp_id);
        chk("drop_end", o_dropped, 0);
        step();
        chk_order("stall5", 0, 200, exp_id);
        i_order_ready = 1'b1;
        step();
        exp_id++;
        chk_order("stall_ask", 1, 210, exp_id);
        step();
        exp_id++;
        wait_valid();
        chk_order("pend_bid", 0, 202, exp_id);
        step();
        exp_id++;
        chk_order("pend_ask", 1, 212, exp_id);
        step();
        exp_id++;
        wait_idle();

        // Run the id up to all-ones, then watch it wrap
        for (int k = 0; exp_id < 255; k++) begin
            quote(1000 + k, 2000 + k);
            wait_idle();
            exp_id += 2;
        end
        quote(300, 301);
        chk_order("wrap_ff", 0, 300, 255);
        step();
        chk_order("wrap_00", 1, 301, 0);
        step();
        wait_idle();

        // Async reset while SEND_ASK waits on ready
        i_order_ready = 1'b0;
        quote(100, 102);
        i_order_ready = 1'b1;
        step();
        i_order_ready = 1'b0;
        chk("pre_rst_side", o_order_side, 1);
        chk("pre_rst_vld", o_order_valid, 1);
        i_reset = 1'b1;
        #1 chk_zero("mid_rst");
        step();
        i_reset = 1'b0;
        step();
        i_order_ready = 1'b1;
        quote(100, 102);
        chk_order("rerun_bid", 0, 100, 0);
        step();
        chk_order("rerun_ask", 1, 102, 1);
        step();
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/order_generator.md
ORDER_GENERATOR -- requirements
Module: order_generator

Interface
REQ-001 Parameter DATA_WIDTH, default 32: price width, integer ticks.
REQ-002 Parameter QTY_WIDTH, default 16: order quantity width.
REQ-003 Parameter ID_WIDTH, default 16: order id width.
REQ-004 Parameter DEFAULT_QTY, default 100: quantity placed on every order.
REQ-005 Parameter MIN_GAP_CYCLES, default 8, legal range >=1: cooldown length after each order burst.
REQ-006 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-007 i_reset  input  1  asynchronous, active-high reset.
REQ-008 i_buy_price  input  DATA_WIDTH  bid quote from the quoting stage.
REQ-009 i_ask_price  input  DATA_WIDTH  ask quote from the quoting stage.
REQ-010 i_data_valid  input  1  quote pair valid, one-cycle pulse per new quote.
REQ-011 i_order_ready  input  1  downstream order-entry sink can accept an order.
REQ-012 o_order_valid  output  1  order payload valid.
REQ-013 o_order_side  output  1  0 = buy, 1 = sell.
REQ-014 o_order_price  output  DATA_WIDTH  order limit price.
REQ-015 o_order_qty  output  QTY_WIDTH  order quantity.
REQ-016 o_order_id  output  ID_WIDTH  sequence id of the presented order.
REQ-017 o_busy  output  1  high in every state except IDLE.
REQ-018 o_dropped  output  1  one-cycle pulse when a quote is discarded unprocessed.
REQ-019 o_crossed  output  1  one-cycle pulse when a quote is rejected as crossed.

Function
REQ-020 The FSM SHALL have the states IDLE, SEND_BID, SEND_ASK and COOLDOWN.
REQ-021 Evaluation of a quote (bid B, ask A), performed in IDLE only: if B!=0 and A!=0 and B>=A, reject, pulse o_crossed the next cycle, stay IDLE.
REQ-022 Otherwise, if B and A both equal the last-launched pair registers, no orders are issued and the FSM stays IDLE (dedup).
REQ-023 Otherwise the FSM latches B and A, updates the last-launched pair, and moves to SEND_BID if B!=0, else to SEND_ASK if A!=0, else stays IDLE.
REQ-024 Latency: a quote evaluated in IDLE at edge N SHALL present o_order_valid=1 from cycle N+1.
REQ-025 Handshake: a transfer occurs at the edge where o_order_valid and i_order_ready are both 1; while valid is high and no transfer has occurred, all payload outputs SHALL be held stable; valid SHALL NOT be deasserted before transfer, except by reset.
REQ-026 SEND_BID presents side=0, price=B; on transfer, go to SEND_ASK if A!=0, else to COOLDOWN.
REQ-027 SEND_ASK presents side=1, price=A; on transfer, go to COOLDOWN.
REQ-028 o_order_qty SHALL equal DEFAULT_QTY whenever o_order_valid=1.
REQ-029 o_order_id SHALL increment by 1 on each transfer, modulo 2^ID_WIDTH, so the all-ones id is followed by 0.
REQ-030 COOLDOWN SHALL last exactly MIN_GAP_CYCLES cycles with o_order_valid=0, then return to IDLE.
REQ-031 A quote with i_data_valid=1 in any non-IDLE state SHALL be stored in a one-deep pending slot; if the slot is already full, it is overwritten by the newer quote and o_dropped pulses.
REQ-032 In IDLE with pending full and i_data_valid=0, the pending quote SHALL be evaluated as in REQ-021..023 and the slot cleared.
REQ-033 In IDLE with pending full and i_data_valid=1 in the same cycle, the new quote SHALL be evaluated, pending is discarded, and o_dropped pulses.
REQ-034 o_dropped and o_crossed SHALL be registered, one cycle wide, and may both be asserted in the same cycle.

Reset
REQ-035 Assertion of i_reset SHALL immediately, without waiting for a clock edge, force state=IDLE and clear the pending slot, the last-launched pair, the cooldown counter and the order id to 0.
REQ-036 During reset, o_order_valid, o_order_side, o_order_price, o_order_qty, o_order_id, o_busy, o_dropped and o_crossed SHALL all be 0.
REQ-037 Reset asserted mid-handshake SHALL drop o_order_valid asynchronously; no transfer is counted for that order.

Verification
REQ-038 B=100, A=102, ready=1 -> buy id0 price 100 at cycle N+1, sell id1 price 102 at N+2, o_busy high through cooldown, IDLE after 8 cooldown cycles.
REQ-039 B=105, A=103 -> o_crossed pulse, no o_order_valid, o_busy stays 0.
REQ-040 100/102 is sent, then 100/102 is sent again -> no orders for the second quote; then B=0, A=101 -> single sell at 101.
REQ-041 ready held 0 for 5 cycles during SEND_BID -> valid and payload stable for all 5 cycles; two further quotes arrive -> exactly one o_dropped pulse, and the last quote is issued after cooldown.
REQ-042 id preloaded to 0xFFFF via 65535 transfers -> the next order carries 0xFFFF and the following one 0x0000.
REQ-043 i_reset asserted while SEND_ASK is waiting on ready -> outputs are 0 before the next edge; after release, 100/102 is not deduped and is fully re-sent.
